// File: rtl/smpl_chk_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : smpl_chk_sb_if
// Brief    : Request/response bundle between the sample-test unit and its
//            scoreboard (triangle, sample, strobes and DUT hit result).
// Revision : 1.0 - initial release
// ============================================================================
interface smpl_chk_sb_if #(
    parameter int SIGFIG = 24,
    parameter int AXIS   = 3
);
    logic [SIGFIG-1:0] tri_R16S    [3][AXIS];
    logic [SIGFIG-1:0] sample_R16S [2];
    logic              validSamp_R16H;
    logic              resp_valid_RxxH;
    logic              hit_RxxH;

    modport master (
        output tri_R16S, sample_R16S, validSamp_R16H, resp_valid_RxxH, hit_RxxH
    );

    modport slave (
        input  tri_R16S, sample_R16S, validSamp_R16H, resp_valid_RxxH, hit_RxxH
    );
endinterface
`default_nettype wire

// File: rtl/smpl_chk_sb.sv
`default_nettype none
// ============================================================================
// Module   : smpl_chk_sb
// Brief    : Sample-test scoreboard: golden edge-function hit, fixed-latency or
//            in-order FIFO retirement, check/error counters and sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module smpl_chk_sb #(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int AXIS       = 3,
    parameter int MODE       = 0,
    parameter int PIPE_DEPTH = 3,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 256,
    parameter int CNT_W      = 32
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    smpl_chk_sb_if.slave                  bus,
    output logic [CNT_W-1:0]              chk_cnt,
    output logic [CNT_W-1:0]              err_cnt,
    output logic                          mismatch_H,
    output logic                          ovf_err,
    output logic                          spur_err,
    output logic                          tmo_err,
    output logic [$clog2(DEPTH):0]        occupancy
);
    localparam int c_DW = SIGFIG + 1;
    localparam int c_EW = 2 * SIGFIG + 3;
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_OW = c_AW + 1;

    // ---------------- golden edge-function model ----------------
    logic signed [c_DW-1:0] w_dx [3];
    logic signed [c_DW-1:0] w_dy [3];
    logic signed [c_EW-1:0] w_e  [3];
    logic                   w_gold;
    logic                   w_unused_cfg;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_dx[i] = $signed({bus.tri_R16S[i][0][SIGFIG-1], bus.tri_R16S[i][0]})
                    - $signed({bus.sample_R16S[0][SIGFIG-1], bus.sample_R16S[0]});
            w_dy[i] = $signed({bus.tri_R16S[i][1][SIGFIG-1], bus.tri_R16S[i][1]})
                    - $signed({bus.sample_R16S[1][SIGFIG-1], bus.sample_R16S[1]});
        end
        w_e[0] = c_EW'(w_dx[0]) * c_EW'(w_dy[1]) - c_EW'(w_dx[1]) * c_EW'(w_dy[0]);
        w_e[1] = c_EW'(w_dx[1]) * c_EW'(w_dy[2]) - c_EW'(w_dx[2]) * c_EW'(w_dy[1]);
        w_e[2] = c_EW'(w_dx[2]) * c_EW'(w_dy[0]) - c_EW'(w_dx[0]) * c_EW'(w_dy[2]);
        // Clockwise winding: e1 strictly negative, e0/e2 may sit on the edge.
        w_gold = (w_e[0][c_EW-1] | ~|w_e[0]) & w_e[1][c_EW-1] & (w_e[2][c_EW-1] | ~|w_e[2]);
    end

    always_comb begin
        w_unused_cfg = (RADIX < SIGFIG);
        for (int i = 0; i < 3; i++) begin
            for (int a = 2; a < AXIS; a++) begin
                w_unused_cfg = w_unused_cfg ^ (^bus.tri_R16S[i][a]);
            end
        end
    end

    // ---------------- retirement path ----------------
    logic w_cmp, w_cmp_gold, w_spur, w_ovf_ev, w_tmo_ev;

    if (MODE == 0) begin : g_fixed
        logic [PIPE_DEPTH-1:0] r_vld_q, w_vld_d, r_gld_q, w_gld_d;
        logic                  w_unused_resp;

        always_comb begin
            w_vld_d = (r_vld_q << 1) | PIPE_DEPTH'(bus.validSamp_R16H);
            w_gld_d = (r_gld_q << 1) | PIPE_DEPTH'(w_gold);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld_q <= '0;
                r_gld_q <= '0;
            end else begin
                r_vld_q <= w_vld_d;
                r_gld_q <= w_gld_d;
            end
        end

        assign w_unused_resp = bus.resp_valid_RxxH;
        assign w_cmp         = r_vld_q[PIPE_DEPTH-1];
        assign w_cmp_gold    = r_gld_q[PIPE_DEPTH-1];
        assign w_spur        = 1'b0;
        assign w_ovf_ev      = 1'b0;
        assign w_tmo_ev      = 1'b0;
        assign occupancy     = '0;
    end else begin : g_fifo
        localparam int c_TW = $clog2(TIMEOUT + 1);

        logic [DEPTH-1:0] r_mem_q, w_mem_d;
        logic [c_AW-1:0]  r_wr_q, w_wr_d, r_rd_q, w_rd_d;
        logic [c_OW-1:0]  r_occ_q, w_occ_d;
        logic [c_TW-1:0]  r_tmo_q, w_tmo_d;
        logic             w_empty, w_full, w_push, w_pop;

        always_comb begin
            w_empty = (r_occ_q == '0);
            w_full  = (r_occ_q == c_OW'(DEPTH));
            // A pop only retires an entry that existed at the start of the cycle.
            w_pop   = bus.resp_valid_RxxH & ~w_empty;
            w_push  = bus.validSamp_R16H & (~w_full | w_pop);
            w_mem_d = r_mem_q;
            if (w_push) begin
                w_mem_d[r_wr_q] = w_gold;
            end
            w_wr_d  = r_wr_q + c_AW'(w_push);
            w_rd_d  = r_rd_q + c_AW'(w_pop);
            w_occ_d = r_occ_q + c_OW'(w_push) - c_OW'(w_pop);
            w_tmo_d = r_tmo_q;
            if (w_pop || w_empty) begin
                w_tmo_d = '0;
            end else if (r_tmo_q != c_TW'(TIMEOUT)) begin
                w_tmo_d = r_tmo_q + c_TW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_mem_q <= '0;
                r_wr_q  <= '0;
                r_rd_q  <= '0;
                r_occ_q <= '0;
                r_tmo_q <= '0;
            end else begin
                r_mem_q <= w_mem_d;
                r_wr_q  <= w_wr_d;
                r_rd_q  <= w_rd_d;
                r_occ_q <= w_occ_d;
                r_tmo_q <= w_tmo_d;
            end
        end

        assign w_cmp      = w_pop;
        assign w_cmp_gold = r_mem_q[r_rd_q];
        assign w_spur     = bus.resp_valid_RxxH & w_empty;
        assign w_ovf_ev   = bus.validSamp_R16H & w_full & ~w_pop;
        assign w_tmo_ev   = (w_tmo_d == c_TW'(TIMEOUT));
        assign occupancy  = r_occ_q;
    end

    // ---------------- counters and sticky flags ----------------
    logic [CNT_W-1:0] r_chk_q, w_chk_d, r_err_q, w_err_d;
    logic             r_mm_q, w_mm_d, r_ovf_q, w_ovf_d, r_spur_q, w_spur_d, r_tmo_err_q, w_tmo_err_d;
    logic             w_err_ev;

    always_comb begin
        w_err_ev = (w_cmp & (w_cmp_gold != bus.hit_RxxH)) | w_spur;
        w_chk_d  = r_chk_q;
        w_err_d  = r_err_q;
        if (w_cmp && (r_chk_q != '1)) begin
            w_chk_d = r_chk_q + CNT_W'(1);
        end
        if (w_err_ev && (r_err_q != '1)) begin
            w_err_d = r_err_q + CNT_W'(1);
        end
        w_mm_d      = w_err_ev;
        w_ovf_d     = r_ovf_q | w_ovf_ev;
        w_spur_d    = r_spur_q | w_spur;
        w_tmo_err_d = r_tmo_err_q | w_tmo_ev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_q     <= '0;
            r_err_q     <= '0;
            r_mm_q      <= 1'b0;
            r_ovf_q     <= 1'b0;
            r_spur_q    <= 1'b0;
            r_tmo_err_q <= 1'b0;
        end else begin
            r_chk_q     <= w_chk_d;
            r_err_q     <= w_err_d;
            r_mm_q      <= w_mm_d;
            r_ovf_q     <= w_ovf_d;
            r_spur_q    <= w_spur_d;
            r_tmo_err_q <= w_tmo_err_d;
        end
    end

    assign chk_cnt    = r_chk_q;
    assign err_cnt    = r_err_q;
    assign mismatch_H = r_mm_q;
    assign ovf_err    = r_ovf_q;
    assign spur_err   = r_spur_q;
    assign tmo_err    = r_tmo_err_q;
endmodule
`default_nettype wire

// File: tb/tb_smpl_chk_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_smpl_chk_sb
// Brief    : Directed bench for smpl_chk_sb: one fixed-latency and one
//            FIFO-mode instance driven from a single linear sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smpl_chk_sb;
    localparam int SF = 24;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    smpl_chk_sb_if #(.SIGFIG(SF), .AXIS(3)) bus0 ();
    smpl_chk_sb_if #(.SIGFIG(SF), .AXIS(3)) bus1 ();

    logic [CW-1:0] chk0, err0, chk1, err1;
    logic          mm0, ovf0, spur0, tmo0, mm1, ovf1, spur1, tmo1;
    logic [3:0]    occ0, occ1;

    smpl_chk_sb #(.SIGFIG(SF), .RADIX(10), .AXIS(3), .MODE(0), .PIPE_DEPTH(3),
                  .DEPTH(8), .TIMEOUT(16), .CNT_W(CW)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .chk_cnt(chk0), .err_cnt(err0),
        .mismatch_H(mm0), .ovf_err(ovf0), .spur_err(spur0), .tmo_err(tmo0),
        .occupancy(occ0)
    );

    smpl_chk_sb #(.SIGFIG(SF), .RADIX(10), .AXIS(3), .MODE(1), .PIPE_DEPTH(3),
                  .DEPTH(8), .TIMEOUT(16), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .chk_cnt(chk1), .err_cnt(err1),
        .mismatch_H(mm1), .ovf_err(ovf1), .spur_err(spur1), .tmo_err(tmo1),
        .occupancy(occ1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_s(input int x, input int y);
        bus0.sample_R16S[0] = 24'(x);
        bus0.sample_R16S[1] = 24'(y);
        bus1.sample_R16S[0] = 24'(x);
        bus1.sample_R16S[1] = 24'(y);
    endtask

    int          xs [4] = '{0, 2048, 2048, -1024};
    int          ys [4] = '{0, 2048, 0, 1024};
    logic [3:0]  tie_g  = 4'b0101;
    logic [7:0]  pat    = 8'b1011_0010;

    initial begin
        rst = 1'b1;
        bus0.validSamp_R16H = 0; bus0.resp_valid_RxxH = 0; bus0.hit_RxxH = 0;
        bus1.validSamp_R16H = 0; bus1.resp_valid_RxxH = 0; bus1.hit_RxxH = 0;
        for (int v = 0; v < 3; v++) begin
            for (int a = 0; a < 3; a++) begin
                bus0.tri_R16S[v][a] = '0;
                bus1.tri_R16S[v][a] = '0;
            end
        end
        // Triangle (0,0), (0,4096), (4096,0)
        bus0.tri_R16S[1][1] = 24'd4096; bus0.tri_R16S[2][0] = 24'd4096;
        bus1.tri_R16S[1][1] = 24'd4096; bus1.tri_R16S[2][0] = 24'd4096;
        set_s(0, 0);
        step(); step();
        chk("rst_chk0", chk0, 0);  chk("rst_err0", err0, 0);  chk("rst_mm0", mm0, 0);
        chk("rst_occ0", occ0, 0);  chk("rst_chk1", chk1, 0);  chk("rst_err1", err1, 0);
        chk("rst_occ1", occ1, 0);  chk("rst_ovf1", ovf1, 0);  chk("rst_spur1", spur1, 0);
        chk("rst_tmo1", tmo1, 0);
        rst = 1'b0;

        // ---- fixed latency: inside sample, hit=1 ----
        bus0.hit_RxxH = 1; set_s(1024, 1024); bus0.validSamp_R16H = 1;
        step(); bus0.validSamp_R16H = 0;
        step(); step();
        chk("m0_not_yet", chk0, 0);
        step();
        chk("m0_in_chk", chk0, 1); chk("m0_in_err", err0, 0); chk("m0_in_mm", mm0, 0);

        // outside sample, hit=0
        bus0.hit_RxxH = 0; set_s(5120, 5120); bus0.validSamp_R16H = 1;
        step(); bus0.validSamp_R16H = 0;
        step(); step(); step();
        chk("m0_out_chk", chk0, 2); chk("m0_out_err", err0, 0);

        // inside sample but DUT says miss
        set_s(1024, 1024); bus0.validSamp_R16H = 1;
        step(); bus0.validSamp_R16H = 0;
        step(); step(); step();
        chk("m0_mm_pulse", mm0, 1); chk("m0_mm_err", err0, 1); chk("m0_mm_chk", chk0, 3);
        step();
        chk("m0_mm_clear", mm0, 0);

        // back-to-back edge-tie samples with correct DUT answers
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                set_s(xs[c], ys[c]);
                bus0.validSamp_R16H = 1;
            end else begin
                bus0.validSamp_R16H = 0;
            end
            if (c >= 3) bus0.hit_RxxH = tie_g[c-3];
            step();
        end
        chk("m0_tie_chk", chk0, 7); chk("m0_tie_err", err0, 1);

        // ---- FIFO mode: fill, overflow, push+pop while full, drain ----
        for (int k = 0; k < 8; k++) begin
            if (pat[k]) set_s(1024, 1024); else set_s(5120, 5120);
            bus1.validSamp_R16H = 1;
            step();
        end
        chk("m1_full_occ", occ1, 8); chk("m1_full_ovf", ovf1, 0);
        set_s(1024, 1024);
        step();
        chk("m1_ovf_flag", ovf1, 1); chk("m1_ovf_occ", occ1, 8);
        set_s(5120, 5120); bus1.resp_valid_RxxH = 1; bus1.hit_RxxH = pat[0];
        step();
        chk("m1_pp_occ", occ1, 8); chk("m1_pp_chk", chk1, 1);
        bus1.validSamp_R16H = 0;
        for (int k = 1; k < 8; k++) begin
            bus1.hit_RxxH = pat[k];
            step();
        end
        bus1.hit_RxxH = 0;
        step();
        bus1.resp_valid_RxxH = 0;
        chk("m1_drain_chk", chk1, 9); chk("m1_drain_occ", occ1, 0);
        chk("m1_drain_err", err1, 0); chk("m1_drain_tmo", tmo1, 0);

        // spurious response
        bus1.resp_valid_RxxH = 1; bus1.hit_RxxH = 1;
        step();
        bus1.resp_valid_RxxH = 0;
        chk("m1_spur_flag", spur1, 1); chk("m1_spur_err", err1, 1);
        chk("m1_spur_chk", chk1, 9);   chk("m1_spur_mm", mm1, 1);

        // timeout after 16 stalled cycles, then a normal pop
        set_s(1024, 1024); bus1.validSamp_R16H = 1;
        step(); bus1.validSamp_R16H = 0;
        repeat (15) step();
        chk("m1_tmo_early", tmo1, 0);
        step();
        chk("m1_tmo_flag", tmo1, 1); chk("m1_tmo_occ", occ1, 1);
        bus1.resp_valid_RxxH = 1; bus1.hit_RxxH = 1;
        step();
        bus1.resp_valid_RxxH = 0;
        chk("m1_tmo_pop_chk", chk1, 10); chk("m1_tmo_pop_occ", occ1, 0);
        chk("m1_tmo_pop_err", err1, 1);  chk("m1_tmo_sticky", tmo1, 1);

        // response and push in the same cycle with empty FIFO: no bypass
        bus1.validSamp_R16H = 1; bus1.resp_valid_RxxH = 1;
        step();
        bus1.resp_valid_RxxH = 0;
        chk("m1_nobyp_err", err1, 2); chk("m1_nobyp_chk", chk1, 10); chk("m1_nobyp_occ", occ1, 1);
        repeat (4) step();
        chk("m1_five_occ", occ1, 5);

        // reset with entries outstanding, strobes active during reset
        rst = 1'b1; bus1.resp_valid_RxxH = 1;
        step();
        chk("m1_rst_occ", occ1, 0);  chk("m1_rst_chk", chk1, 0);  chk("m1_rst_err", err1, 0);
        chk("m1_rst_ovf", ovf1, 0);  chk("m1_rst_spur", spur1, 0); chk("m1_rst_tmo", tmo1, 0);
        chk("m1_rst_mm", mm1, 0);    chk("m0_rst_chk", chk0, 0);
        rst = 1'b0; bus1.validSamp_R16H = 0;
        step();
        bus1.resp_valid_RxxH = 0;
        chk("m1_post_spur", spur1, 1); chk("m1_post_err", err1, 1);
        chk("m1_post_chk", chk1, 0);   chk("m1_post_occ", occ1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
